// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types and elaboration-time constant helpers for the
// rotation-mode CORDIC. All helpers are evaluated only while computing
// localparams; none of them produces hardware.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam real PI_R = 3.14159265358979323846;

  // Round a real value to a fixed-point integer with frac fraction bits.
  // Rounding is half away from zero.
  function automatic int fx_round(input real v, input int frac);
    real s;
    s = v * (2.0 ** frac);
    if (s >= 0.0) return $rtoi(s + 0.5);
    else          return -$rtoi(0.5 - s);
  endfunction

  // atan(2^-i) in radians. i = 0 is exact. Otherwise a Taylor series is used,
  // which converges quickly because the argument is at most 0.5.
  function automatic real atan_r(input int i);
    real x;
    real term;
    real acc;
    if (i == 0) return PI_R / 4.0;
    x    = 1.0 / (2.0 ** i);
    term = x;
    acc  = 0.0;
    for (int n = 0; n < 40; n++) begin
      if ((n % 2) == 0) acc = acc + term / real'(2 * n + 1);
      else              acc = acc - term / real'(2 * n + 1);
      term = term * x * x;
    end
    return acc;
  endfunction

  // Square root by Newton iteration. This avoids depending on $sqrt during
  // elaboration.
  function automatic real sqrt_r(input real v);
    real r;
    r = (v > 1.0) ? v : 1.0;
    for (int n = 0; n < 60; n++) r = 0.5 * (r + v / r);
    return r;
  endfunction

  // CORDIC gain compensation: product of 1/sqrt(1+2^-2i) over iters stages.
  function automatic real kgain_r(input int iters);
    real p;
    p = 1.0;
    for (int i = 0; i < iters; i++) p = p * (1.0 + 1.0 / (4.0 ** i));
    return 1.0 / sqrt_r(p);
  endfunction

  function automatic int pi_fx(input int frac);
    return fx_round(PI_R, frac);
  endfunction

  function automatic int half_pi_fx(input int frac);
    return fx_round(PI_R / 2.0, frac);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one combinational rotation-mode micro-rotation. The shift
// index selects 2^-i. The matching arctangent constant is supplied by the
// caller.
module cordic_stage #(
  parameter int WIDTH = 22,
  parameter int IW    = 5
) (
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] y_i,
  input  logic signed [WIDTH-1:0] z_i,
  input  logic signed [WIDTH-1:0] atan_i,
  input  logic        [IW-1:0]    shift_i,
  output logic signed [WIDTH-1:0] x_o,
  output logic signed [WIDTH-1:0] y_o,
  output logic signed [WIDTH-1:0] z_o
);

  logic                    neg;
  logic signed [WIDTH-1:0] x_sh;
  logic signed [WIDTH-1:0] y_sh;

  // A negative residual angle rotates clockwise. Otherwise the stage rotates
  // counter-clockwise.
  always_comb begin
    neg  = z_i[WIDTH-1];
    x_sh = x_i >>> shift_i;
    y_sh = y_i >>> shift_i;
    x_o  = neg ? (x_i + y_sh)   : (x_i - y_sh);
    y_o  = neg ? (y_i - x_sh)   : (y_i + x_sh);
    z_o  = neg ? (z_i + atan_i) : (z_i - atan_i);
  end

endmodule

// File: rtl/cordic_rot_param.sv
// cordic_rot_param: iterative rotation-mode CORDIC producing cos and sin of a
// fixed-point angle. UNROLL micro-rotations are applied per clock, for ITERS
// micro-rotations in total.
// Optional feature macro: CORDIC_QUAD_EN. When it is defined, a PRE cycle
// folds angles in [-pi, pi] into [-pi/2, pi/2]. The results are negated when
// the angle was folded.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   PRE   | quadrant fold of the latched angle (CORDIC_QUAD_EN only)
//   RUN   | UNROLL chained micro-rotations per cycle until ITERS are done
module cordic_rot_param
  import cordic_pkg::*;
#(
  parameter int WIDTH  = 22,
  parameter int FRAC   = 18,
  parameter int ITERS  = 16,
  parameter int UNROLL = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] angle,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cos_out,
  output logic [WIDTH-1:0] sin_out
);

  localparam int SW = $clog2(ITERS + 1);
  localparam int IW = $clog2(WIDTH);
  localparam logic signed [WIDTH-1:0] KGAIN = WIDTH'(fx_round(kgain_r(ITERS), FRAC));
  localparam logic [SW-1:0] STEP_LAST = SW'(ITERS - UNROLL);
  localparam logic [SW-1:0] STEP_INC  = SW'(UNROLL);
`ifdef CORDIC_QUAD_EN
  localparam logic signed [WIDTH-1:0] PI_FX      = WIDTH'(pi_fx(FRAC));
  localparam logic signed [WIDTH-1:0] HALF_PI_FX = WIDTH'(half_pi_fx(FRAC));
`endif

  state_e                  state_q;
  logic                    busy_q;
  logic                    done_q;
  logic signed [WIDTH-1:0] x_q;
  logic signed [WIDTH-1:0] y_q;
  logic signed [WIDTH-1:0] z_q;
  logic signed [WIDTH-1:0] cos_q;
  logic signed [WIDTH-1:0] sin_q;
  logic        [SW-1:0]    step_q;
`ifdef CORDIC_QUAD_EN
  logic                    flip_q;
`endif

  logic signed [WIDTH-1:0] x_d;
  logic signed [WIDTH-1:0] y_d;
  logic signed [WIDTH-1:0] z_d;

  logic signed [WIDTH-1:0] atan_rom [WIDTH];
  logic signed [WIDTH-1:0] cx [UNROLL+1];
  logic signed [WIDTH-1:0] cy [UNROLL+1];
  logic signed [WIDTH-1:0] cz [UNROLL+1];

  // The arctangent table is computed during elaboration. Only the first ITERS
  // entries are ever addressed.
  for (genvar j = 0; j < WIDTH; j++) begin : g_atan
    localparam logic signed [WIDTH-1:0] ATAN_J = WIDTH'(fx_round(atan_r(j), FRAC));
    assign atan_rom[j] = ATAN_J;
  end

  assign cx[0] = x_q;
  assign cy[0] = y_q;
  assign cz[0] = z_q;

  // Chain of UNROLL micro-rotations. Stage k handles iteration step_q+k.
  for (genvar k = 0; k < UNROLL; k++) begin : g_stage
    logic [IW-1:0] idx;
    assign idx = IW'(step_q) + IW'(k);
    cordic_stage #(
      .WIDTH (WIDTH),
      .IW    (IW)
    ) u_stage (
      .x_i    (cx[k]),
      .y_i    (cy[k]),
      .z_i    (cz[k]),
      .atan_i (atan_rom[idx]),
      .shift_i(idx),
      .x_o    (cx[k+1]),
      .y_o    (cy[k+1]),
      .z_o    (cz[k+1])
    );
  end

  assign x_d = cx[UNROLL];
  assign y_d = cy[UNROLL];
  assign z_d = cz[UNROLL];

  // Control FSM and datapath registers. Reset takes priority, and done is a
  // single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      step_q  <= '0;
`ifdef CORDIC_QUAD_EN
      flip_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q    <= KGAIN;
            y_q    <= '0;
            z_q    <= angle;
            step_q <= '0;
            busy_q <= 1'b1;
`ifdef CORDIC_QUAD_EN
            state_q <= PRE;
`else
            state_q <= RUN;
`endif
          end
        end
`ifdef CORDIC_QUAD_EN
        PRE: begin
          if (z_q > HALF_PI_FX) begin
            z_q    <= z_q - PI_FX;
            flip_q <= 1'b1;
          end else if (z_q < -HALF_PI_FX) begin
            z_q    <= z_q + PI_FX;
            flip_q <= 1'b1;
          end else begin
            flip_q <= 1'b0;
          end
          state_q <= RUN;
        end
`endif
        RUN: begin
          x_q    <= x_d;
          y_q    <= y_d;
          z_q    <= z_d;
          step_q <= step_q + STEP_INC;
          if (step_q == STEP_LAST) begin
`ifdef CORDIC_QUAD_EN
            cos_q <= flip_q ? -x_d : x_d;
            sin_q <= flip_q ? -y_d : y_d;
`else
            cos_q <= x_d;
            sin_q <= y_d;
`endif
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign cos_out = cos_q;
  assign sin_out = sin_q;

endmodule

// File: doc/cordic_rot_param.md
Name: cordic_rot_param

Overview:
- Parametrised iterative CORDIC in rotation mode. Returns both cos and sin of a fixed-point input angle.
- Performs UNROLL micro-rotations per clock, for ITERS micro-rotations in total.
- Successor to the fixed 22-bit, four-per-cycle cos-only engine.
- Sits in the trig datapath, feeding the floating-point conversion stage.
- Uses a start/busy/done handshake.

Parameters:
- WIDTH, 22: bit width of angle, internal x/y/z and outputs (two's complement).
- FRAC, 18: number of fraction bits. Applies uniformly to angle (radians) and to outputs.
- ITERS, 16: total micro-rotations. Must be a multiple of UNROLL; must be ≤ WIDTH-1.
- UNROLL, 4: micro-rotations per clock. Allowed values: 1, 2, 4, 8.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only when idle.
- angle  in  WIDTH  signed radians, FRAC fraction bits. Latched on an accepted start.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when results become valid.
- cos_out  out  WIDTH  signed cos(angle), FRAC fraction bits.
- sin_out  out  WIDTH  signed sin(angle), FRAC fraction bits.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, cos_out=0, sin_out=0; internal x/y/z/step cleared.
- States:
  - IDLE: on start=1, load x=KGAIN, y=0, z=angle, step=0; go to RUN; busy=1.
  - RUN: each cycle apply UNROLL chained micro-rotations, i=step..step+UNROLL-1; step+=UNROLL. When step reaches ITERS: cos_out<=x, sin_out<=y, done<=1, busy<=0, go to IDLE.
- Micro-rotation i:
  - d = z[WIDTH-1] (1 = negative).
  - x' = x + (d ? y>>>i : -(y>>>i))
  - y' = y + (d ? -(x>>>i) : x>>>i)
  - z' = z + (d ? ATAN[i] : -ATAN[i])
  - All shifts are arithmetic. Every stage in a cycle uses the previous stage's combinational result.
- Arithmetic: two's-complement wrap, no saturation. WIDTH-FRAC-1 integer bits give the headroom; |x|,|y| ≤ 1.65 is always in range.
- Latency: start accepted at edge N; done high in the cycle after edge N+ITERS/UNROLL.
  - Default parameters: 4 cycles.
  - UNROLL=1: 16 cycles.
- Outputs hold their last value until the next completion. done is never high for two consecutive cycles.
- start while busy: ignored. The angle is not re-latched.
- start in the same cycle as done (state IDLE next edge): accepted on the following edge only. No same-edge restart.
- reset mid-operation: wins over everything. Returns to IDLE with outputs cleared and no done pulse.
- Input range: without the optional feature, angle must be within [-pi/2, +pi/2]. Results outside that range are undefined but must not hang the FSM.

Optional Feature:
- Macro: CORDIC_QUAD_EN.
- Defined:
  - IDLE→RUN inserts one PRE cycle that folds the angle into [-pi/2, pi/2].
  - If angle > pi/2: z=angle-pi, flip=1. If angle < -pi/2: z=angle+pi, flip=1.
  - On completion with flip=1, cos_out and sin_out are both negated.
  - Full input range is [-pi, +pi]. Latency becomes ITERS/UNROLL+1.
- Undefined: no PRE cycle and no flip register; behaviour as above.

Decomposition:
- Package cordic_pkg holds:
  - function/constant table ATAN[0..WIDTH-1] = round(atan(2^-i)·2^FRAC);
  - KGAIN = round(prod 1/sqrt(1+2^-2i) over ITERS · 2^FRAC);
  - PI_FX and HALF_PI_FX;
  - state enum {IDLE, PRE, RUN}.
- Sub-module cordic_stage: combinational single micro-rotation with a shift-index input. Instantiated UNROLL times in a chain, with i = step+k.

Test Plan (defaults, tolerance ±8 LSB):
- Angle 0: start with angle=0 → done after 4 cycles; cos_out≈262144, sin_out≈0; busy high exactly 4 cycles.
- Angle pi/4: angle=205887 → cos_out≈185364, sin_out≈185364.
- Angle -pi/3: angle=-274517 → cos_out≈131072, sin_out≈-227023.
- Handshake: start pulsed again 2 cycles after the first start with a different angle → ignored; single done; result matches the first angle.
- Reset mid-operation: reset asserted during cycle 2 of RUN → busy=0, done never pulses, outputs=0; a subsequent start completes normally.
- Parameter and feature sweep:
  - UNROLL=1 and UNROLL=8 (ITERS=16): latency 16 and 2 cycles, identical results to UNROLL=4.
  - With CORDIC_QUAD_EN, angle=617662 (3pi/4) → cos≈-185364, sin≈185364, latency 5.
